// File: rtl/commit_unit_pkg.sv
// ---------------------------------------------------------------------------
// commit_unit_pkg: opcodes, register numbers, instruction fields and FSM codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package commit_unit_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RD_MSB = 26;
  localparam int RD_LSB = 22;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  localparam logic [4:0] REG_RA     = 5'd31;
  localparam logic [4:0] REG_STATUS = 5'd30;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/commit_decode.sv
// ---------------------------------------------------------------------------
// commit_decode: maps opcode/rd to {writes, destination register}
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module commit_decode (
  input  logic [4:0] i_op,
  input  logic [4:0] i_rd,
  output logic       o_writes,
  output logic [4:0] o_dest
);
  import commit_unit_pkg::*;

  always_comb begin
    o_writes = 1'b0;
    o_dest   = 5'd0;
    case (i_op)
      OP_ALU, OP_ADDI, OP_LW: begin
        o_writes = 1'b1;
        o_dest   = i_rd;
      end
      OP_JAL: begin
        o_writes = 1'b1;
        o_dest   = REG_RA;
      end
      OP_SETX: begin
        o_writes = 1'b1;
        o_dest   = REG_STATUS;
      end
      default: begin
        o_writes = 1'b0;
        o_dest   = 5'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/commit_unit.sv
// ---------------------------------------------------------------------------
// commit_unit: in-order retirement from the ROB head with halt freeze
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module commit_unit #(
  parameter logic [4:0] HALT_OP = 5'b11111,
  parameter int         CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rob_is_empty,
  input  logic [31:0]      rob_head_instr,
  input  logic [31:0]      rob_head_val,
  input  logic             rob_head_ready,
  input  logic             rf_busy,
  output logic             rob_pop,
  output logic             rf_wEn,
  output logic [4:0]       rf_addr,
  output logic [31:0]      rf_data,
  output logic             halted,
  output logic [CNT_W-1:0] retire_count
);
  import commit_unit_pkg::*;

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic             w_commit_ok;
  logic             w_writes;
  logic [4:0]       w_dest;
  logic [4:0]       w_op;
  logic             r_wen;
  logic [4:0]       r_addr;
  logic [31:0]      r_data;
  logic [CNT_W-1:0] r_count;

  assign w_op = rob_head_instr[OP_MSB:OP_LSB];

  commit_decode u_decode (
    .i_op     (w_op),
    .i_rd     (rob_head_instr[RD_MSB:RD_LSB]),
    .o_writes (w_writes),
    .o_dest   (w_dest)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_RUN && w_commit_ok && w_op == HALT_OP)
      w_state_next = ST_HALTED;
  end

  // Reset gating keeps the pop low while reset holds the FSM in RUN.
  always_comb begin
    w_commit_ok = (r_state == ST_RUN) && !reset && !rob_is_empty && rob_head_ready
                  && (rob_head_instr != 32'd0) && !rf_busy;
    rob_pop     = w_commit_ok;
    halted      = (r_state == ST_HALTED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wen   <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
      r_count <= '0;
    end else if (w_commit_ok) begin
      r_wen   <= w_writes && (w_dest != 5'd0);
      r_addr  <= w_dest;
      r_data  <= rob_head_val;
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign rf_wEn       = r_wen;
  assign rf_addr      = r_addr;
  assign rf_data      = r_data;
  assign retire_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_commit_unit: directed self-checking bench for commit_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_commit_unit;

  logic        clock;
  logic        reset;
  logic        rob_is_empty;
  logic [31:0] rob_head_instr;
  logic [31:0] rob_head_val;
  logic        rob_head_ready;
  logic        rf_busy;
  logic        rob_pop;
  logic        rf_wEn;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        halted;
  logic [31:0] retire_count;

  int checks   = 0;
  int failures = 0;

  commit_unit #(.HALT_OP(5'b11111), .CNT_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .rob_is_empty   (rob_is_empty),
    .rob_head_instr (rob_head_instr),
    .rob_head_val   (rob_head_val),
    .rob_head_ready (rob_head_ready),
    .rf_busy        (rf_busy),
    .rob_pop        (rob_pop),
    .rf_wEn         (rf_wEn),
    .rf_addr        (rf_addr),
    .rf_data        (rf_data),
    .halted         (halted),
    .retire_count   (retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic head(input logic [31:0] instr, input logic [31:0] val, input logic rdy);
    rob_head_instr = instr;
    rob_head_val   = val;
    rob_head_ready = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rob_is_empty = 1'b0;
    rf_busy = 1'b0;
    rob_head_instr = 32'h0040_0000;
    rob_head_val = 32'h55;
    rob_head_ready = 1'b1;
    #2;
    chk("pop_in_reset", {31'd0, rob_pop}, 32'd0);
    tick();
    tick();
    chk("rst_wen", {31'd0, rf_wEn}, 32'd0);
    chk("rst_addr", {27'd0, rf_addr}, 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_cnt", retire_count, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;
    #1;

    // First commit: ALU rd=1
    chk("pop_alu", {31'd0, rob_pop}, 32'd1);
    tick();
    chk("alu_wen", {31'd0, rf_wEn}, 32'd1);
    chk("alu_addr", {27'd0, rf_addr}, 32'd1);
    chk("alu_data", rf_data, 32'h55);
    chk("alu_cnt", retire_count, 32'd1);

    // Stall on rf_busy for three cycles
    rf_busy = 1'b1;
    head(32'h0080_0000, 32'h66, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_pop", {31'd0, rob_pop}, 32'd0);
      tick();
      chk("stall_wen", {31'd0, rf_wEn}, 32'd0);
    end
    chk("stall_cnt", retire_count, 32'd1);
    rf_busy = 1'b0;
    #1;
    chk("unstall_pop", {31'd0, rob_pop}, 32'd1);
    tick();
    chk("unstall_wen", {31'd0, rf_wEn}, 32'd1);
    chk("unstall_addr", {27'd0, rf_addr}, 32'd2);
    chk("unstall_data", rf_data, 32'h66);
    chk("unstall_cnt", retire_count, 32'd2);

    // Store-type op 00111 rd=5: popped, no write
    head(32'h3940_0000, 32'h77, 1'b1);
    chk("sw_pop", {31'd0, rob_pop}, 32'd1);
    tick();
    chk("sw_wen", {31'd0, rf_wEn}, 32'd0);
    chk("sw_cnt", retire_count, 32'd3);

    // ALU with rd=0 (nonzero word): popped, no write
    head(32'h0000_0001, 32'h88, 1'b1);
    chk("r0_pop", {31'd0, rob_pop}, 32'd1);
    tick();
    chk("r0_wen", {31'd0, rf_wEn}, 32'd0);
    chk("r0_cnt", retire_count, 32'd4);

    // jal writes r31
    head(32'h1800_0000, 32'h1234, 1'b1);
    tick();
    chk("jal_wen", {31'd0, rf_wEn}, 32'd1);
    chk("jal_addr", {27'd0, rf_addr}, 32'd31);
    chk("jal_data", rf_data, 32'h1234);

    // setx writes r30
    head(32'hA800_0000, 32'h9, 1'b1);
    tick();
    chk("setx_wen", {31'd0, rf_wEn}, 32'd1);
    chk("setx_addr", {27'd0, rf_addr}, 32'd30);
    chk("setx_cnt", retire_count, 32'd6);

    // Invalid head word 0, not-ready head, empty ROB
    head(32'h0, 32'hAA, 1'b1);
    chk("zero_pop", {31'd0, rob_pop}, 32'd0);
    tick();
    chk("zero_wen", {31'd0, rf_wEn}, 32'd0);
    chk("zero_hold_addr", {27'd0, rf_addr}, 32'd30);
    head(32'h0040_0000, 32'hBB, 1'b0);
    chk("notrdy_pop", {31'd0, rob_pop}, 32'd0);
    tick();
    chk("notrdy_wen", {31'd0, rf_wEn}, 32'd0);
    rob_is_empty = 1'b1;
    head(32'h0040_0000, 32'hCC, 1'b1);
    chk("empty_pop", {31'd0, rob_pop}, 32'd0);
    tick();
    chk("empty_wen", {31'd0, rf_wEn}, 32'd0);
    chk("empty_cnt", retire_count, 32'd6);
    chk("hold_data", rf_data, 32'h9);
    rob_is_empty = 1'b0;

    // Back-to-back addi rd=3 with vals 1..4
    for (int i = 1; i <= 4; i++) begin
      head(32'h28C0_0000, 32'(i), 1'b1);
      chk("b2b_pop", {31'd0, rob_pop}, 32'd1);
      tick();
      chk("b2b_wen", {31'd0, rf_wEn}, 32'd1);
      chk("b2b_addr", {27'd0, rf_addr}, 32'd3);
      chk("b2b_data", rf_data, 32'(i));
    end
    chk("b2b_cnt", retire_count, 32'd10);

    // Reset between a pop and the next edge
    head(32'h0040_0000, 32'hDD, 1'b1);
    chk("mid_pop", {31'd0, rob_pop}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_pop_rst", {31'd0, rob_pop}, 32'd0);
    chk("mid_cnt_rst", retire_count, 32'd0);
    chk("mid_wen_rst", {31'd0, rf_wEn}, 32'd0);
    rob_head_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_wen", {31'd0, rf_wEn}, 32'd0);
    chk("post_rst_cnt", retire_count, 32'd0);

    // HALT followed by a ready ALU instruction
    head(32'hF800_0000, 32'hEE, 1'b1);
    chk("halt_pop", {31'd0, rob_pop}, 32'd1);
    tick();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_wen", {31'd0, rf_wEn}, 32'd0);
    chk("halt_cnt", retire_count, 32'd1);
    head(32'h0040_0000, 32'hFF, 1'b1);
    chk("after_halt_pop", {31'd0, rob_pop}, 32'd0);
    tick();
    tick();
    chk("after_halt_cnt", retire_count, 32'd1);
    chk("after_halt_wen", {31'd0, rf_wEn}, 32'd0);
    chk("still_halted", {31'd0, halted}, 32'd1);
    rob_head_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("halt_cleared", {31'd0, halted}, 32'd0);
    tick();
    reset = 1'b0;
    head(32'h0040_0000, 32'h42, 1'b1);
    chk("resume_pop", {31'd0, rob_pop}, 32'd1);
    tick();
    chk("resume_data", rf_data, 32'h42);
    chk("resume_cnt", retire_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage directly downstream of the reorder buffer. Each cycle it inspects the ROB head and pops it once the head is valid and ready. It then registers the architectural register-file write for that instruction and keeps a retired-instruction count. A HALT instruction reaching commit freezes retirement until reset.

## Interface
Parameters:
- HALT_OP, 5'b11111: opcode (bits [31:27]) that stops retirement.
- CNT_W, 32: width of retire counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rob_is_empty  in  1  ROB empty flag.
- rob_head_instr  in  32  instruction word at ROB head; 0 means no valid entry.
- rob_head_val  in  32  result value at ROB head.
- rob_head_ready  in  1  head has finished execution.
- rf_busy  in  1  register-file write port unavailable this cycle.
- rob_pop  out  1  combinational pop request to ROB.
- rf_wEn  out  1  registered write enable.
- rf_addr  out  5  registered destination register.
- rf_data  out  32  registered write data.
- halted  out  1  retirement frozen.
- retire_count  out  CNT_W  instructions retired since reset.

## Operation
- commit_ok = state==RUN & !rob_is_empty & rob_head_ready & (rob_head_instr != 0) & !rf_busy.
- rob_pop = commit_ok. It is purely combinational from registered ROB head outputs plus rf_busy and state.
- Destination decode from opcode op = instr[31:27] and rd = instr[26:22]:
  - Ops 00000, 00101 and 01000 write rd.
  - Op 00011 (jal) writes r31.
  - Op 10101 (setx) writes r30.
  - All other ops write nothing.
  - A destination of r0 suppresses the write.
- On commit_ok, the next edge does the following:
  - rf_wEn <= writes & dest!=0.
  - rf_addr <= dest.
  - rf_data <= rob_head_val.
  - retire_count increments by 1. It wraps modulo 2^CNT_W.
- Without commit_ok, rf_wEn is 0 next cycle. rf_addr and rf_data hold their values.
- FSM has two states, RUN and HALTED:
  - RUN→HALTED on the edge where commit_ok is true and op==HALT_OP. The HALT instruction itself is popped and counted, and performs no write.
  - HALTED is left only by reset.
  - halted = (state==HALTED).
- Back-to-back commits occur at one per cycle. The ROB advances its head at the same edge as the pop.

## Timing
- Reset values: state RUN, rf_wEn 0, rf_addr 0, rf_data 0, retire_count 0, halted 0. rob_pop is 0 while reset is asserted.
- Latency from head ready to rob_pop is 0 cycles (same cycle). Latency from pop to rf_wEn is 1 cycle.
- When rf_busy is asserted, rob_pop is held low that cycle and the head is retried next cycle. No value is dropped or duplicated.
- When the ROB is empty, or the head is present but not ready, no pop occurs and rf_wEn is 0.
- A head_instr of 0 with the ROB non-empty is treated as not valid; no pop occurs.
- If reset is asserted mid-stream, all registers clear immediately (asynchronously). No write issues on the first edge after reset deasserts unless commit_ok holds.
- If a HALT is followed immediately by a ready instruction, the following instruction is not popped and the count stops at the HALT.

## Structure
- Shared package: opcode constants (OP_ALU, OP_ADDI, OP_LW, OP_JAL, OP_SETX), register constants (REG_RA=31, REG_STATUS=30), FSM state encoding, and instruction field positions.
- One sub-module, commit_decode: combinational opcode→{writes, dest} mapping, reusable by dispatch.
- The top level holds the FSM, the output registers and the counter.

## Test plan
- Reset check: after reset, all outputs 0 and halted 0. Present head instr 0x00400000 (ALU, rd=1), val 0x55, ready=1 → rob_pop=1 same cycle; next cycle rf_wEn=1, rf_addr=1, rf_data=0x55, retire_count=1.
- Stall ordering: head ready but rf_busy=1 for 3 cycles → rob_pop=0 and rf_wEn=0 throughout. Release rf_busy → single commit, retire_count=1.
- No-write cases: a sw-type op 00111 with rd=5 → pop, rf_wEn=0, count increments. An ALU op with rd=0 → pop, rf_wEn=0. A jal → rf_addr=31.
- Back-to-back: 4 ready heads on consecutive cycles with vals 1,2,3,4 → rf_data sequence 1,2,3,4 on consecutive cycles, final count=4.
- Halt: HALT at head followed by a ready ALU instr → HALT popped, halted=1 next cycle, the ALU instr is never popped, count frozen. Only reset clears halted.
- Empty and mid-operation reset: rob_is_empty=1 with ready=1 → no pop. Asserting reset between a pop and the next edge → rf_wEn stays 0 and count=0.
